// File: rtl/alu_pkg.sv
// Shared ALU definitions: one-hot control bit positions, MIPS opcode/funct codes
// and the control-word width used by the issue stage and its decoder.
package alu_pkg;

    localparam int ALU_CTRL_W = 12;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic [ALU_CTRL_W-1:0] alu_onehot(input int idx);
        logic [ALU_CTRL_W-1:0] w;
        w = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ID->EXE issue bus: ID-side handshake and operands in, registered ALU request out.
// master = upstream/EXE environment, slave = the issue stage.
interface alu_issue_if;
    import alu_pkg::*;

    logic                  id_valid;
    logic                  id_ready;
    logic [31:0]           id_inst;
    logic [31:0]           rs_value;
    logic [31:0]           rt_value;
    logic                  flush;
    logic                  exe_valid;
    logic                  exe_ready;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [31:0]           alu_src1;
    logic [31:0]           alu_src2;
    logic [4:0]            exe_dest;
    logic                  exe_wen;
    logic                  check_overflow;
    logic                  illegal;

    modport master (
        output id_valid, id_inst, rs_value, rt_value, flush, exe_ready,
        input  id_ready, exe_valid, alu_control, alu_src1, alu_src2,
               exe_dest, exe_wen, check_overflow, illegal
    );

    modport slave (
        input  id_valid, id_inst, rs_value, rt_value, flush, exe_ready,
        output id_ready, exe_valid, alu_control, alu_src1, alu_src2,
               exe_dest, exe_wen, check_overflow, illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational MIPS ALU-op decoder: control word, operands, destination and flags.
// ALU_ISSUE_OVF_CHECK_EN enables the trap-on-overflow flag for ADD/SUB/ADDI.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0]           inst,
    input  logic [31:0]           rs_value,
    input  logic [31:0]           rt_value,
    output logic [ALU_CTRL_W-1:0] control,
    output logic [31:0]           src1,
    output logic [31:0]           src2,
    output logic [4:0]            dest,
    output logic                  wen,
    output logic                  ovf,
    output logic                  illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  sa;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic        unused_rs_field;

    assign opcode   = inst[31:26];
    assign rt_field = inst[20:16];
    assign rd_field = inst[15:11];
    assign sa       = inst[10:6];
    assign funct    = inst[5:0];
    assign simm     = {{16{inst[15]}}, inst[15:0]};
    assign zimm     = {16'd0, inst[15:0]};
    // rs arrives already read from the register file
    assign unused_rs_field = ^inst[25:21];

    always_comb begin
        control = '0;
        src1    = rs_value;
        src2    = rt_value;
        dest    = rt_field;
        illegal = 1'b0;

        if (opcode == OP_SPECIAL) begin
            dest = rd_field;
            case (funct)
                FN_SLL:  begin control = alu_onehot(ALU_SLL); src1 = {27'd0, sa}; end
                FN_SRL:  begin control = alu_onehot(ALU_SRL); src1 = {27'd0, sa}; end
                FN_SRA:  begin control = alu_onehot(ALU_SRA); src1 = {27'd0, sa}; end
                FN_SLLV: control = alu_onehot(ALU_SLL);
                FN_SRLV: control = alu_onehot(ALU_SRL);
                FN_SRAV: control = alu_onehot(ALU_SRA);
                FN_ADD,
                FN_ADDU: control = alu_onehot(ALU_ADD);
                FN_SUB,
                FN_SUBU: control = alu_onehot(ALU_SUB);
                FN_AND:  control = alu_onehot(ALU_AND);
                FN_OR:   control = alu_onehot(ALU_OR);
                FN_XOR:  control = alu_onehot(ALU_XOR);
                FN_NOR:  control = alu_onehot(ALU_NOR);
                FN_SLT:  control = alu_onehot(ALU_SLT);
                FN_SLTU: control = alu_onehot(ALU_SLTU);
                default: illegal = 1'b1;
            endcase
        end else begin
            case (opcode)
                OP_ADDI,
                OP_ADDIU: begin control = alu_onehot(ALU_ADD);  src2 = simm; end
                OP_SLTI:  begin control = alu_onehot(ALU_SLT);  src2 = simm; end
                OP_SLTIU: begin control = alu_onehot(ALU_SLTU); src2 = simm; end
                OP_ANDI:  begin control = alu_onehot(ALU_AND);  src2 = zimm; end
                OP_ORI:   begin control = alu_onehot(ALU_OR);   src2 = zimm; end
                OP_XORI:  begin control = alu_onehot(ALU_XOR);  src2 = zimm; end
                OP_LUI:   begin control = alu_onehot(ALU_LUI);  src1 = '0; src2 = zimm; end
                default:  illegal = 1'b1;
            endcase
        end

        // an unsupported encoding travels down the pipe as an inert bubble
        if (illegal) begin
            control = '0;
            src1    = '0;
            src2    = '0;
            dest    = '0;
        end
    end

    assign wen = ~illegal & (dest != 5'd0);

`ifdef ALU_ISSUE_OVF_CHECK_EN
    assign ovf = ((opcode == OP_SPECIAL) && ((funct == FN_ADD) || (funct == FN_SUB)))
               || (opcode == OP_ADDI);
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/alu_issue.sv
// ID->EXE issue stage: decodes the ID instruction and holds it in a one-entry
// valid/ready pipeline register feeding the ALU. Build option: ALU_ISSUE_OVF_CHECK_EN.
module alu_issue
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    alu_issue_if.slave bus
);

    logic [ALU_CTRL_W-1:0] d_control;
    logic [31:0]           d_src1;
    logic [31:0]           d_src2;
    logic [4:0]            d_dest;
    logic                  d_wen;
    logic                  d_ovf;
    logic                  d_illegal;
    logic                  load;

    alu_decoder u_decoder (
        .inst     (bus.id_inst),
        .rs_value (bus.rs_value),
        .rt_value (bus.rt_value),
        .control  (d_control),
        .src1     (d_src1),
        .src2     (d_src2),
        .dest     (d_dest),
        .wen      (d_wen),
        .ovf      (d_ovf),
        .illegal  (d_illegal)
    );

    assign bus.id_ready = ~bus.exe_valid | bus.exe_ready;
    assign load         = bus.id_ready & bus.id_valid & ~bus.flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.exe_valid      <= 1'b0;
            bus.alu_control    <= '0;
            bus.alu_src1       <= '0;
            bus.alu_src2       <= '0;
            bus.exe_dest       <= '0;
            bus.exe_wen        <= 1'b0;
            bus.check_overflow <= 1'b0;
            bus.illegal        <= 1'b0;
        end else begin
            if (bus.flush) begin
                bus.exe_valid <= 1'b0;
            end else if (bus.id_ready) begin
                bus.exe_valid <= bus.id_valid;
            end
            if (load) begin
                bus.alu_control    <= d_control;
                bus.alu_src1       <= d_src1;
                bus.alu_src2       <= d_src2;
                bus.exe_dest       <= d_dest;
                bus.exe_wen        <= d_wen;
                bus.check_overflow <= d_ovf;
                bus.illegal        <= d_illegal;
            end
        end
    end

endmodule
